ex_mem_pipe_reg: RTL
====================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register for the five-stage core. Captures EX results (GPR write,
//  HI/LO write) and presents them to MEM. Obeys the 6-bit stall vector from the control module:
//  inserts a bubble when EX stalls but MEM runs, and holds outputs when both stall.
//  Adds a synchronous flush and a valid bit. Carries the multi-cycle accumulator (hilo/cnt)
//  back to EX across stall cycles for madd/msub/div.
// PARAMETERS
//  DATA_W    32  GPR / HI / LO data width
//  ADDR_W     5  GPR destination address width
//  ACC_W     64  multi-cycle accumulator width (normally 2*DATA_W)
//  CNT_W      2  multi-cycle step counter width
//  STALL_W    6  stall vector width
//  STAGE_IDX  3  stall bit of the upstream (EX) stage; bit STAGE_IDX+1 is MEM; STAGE_IDX<=STALL_W-2
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  stall      in   STALL_W  per-stage stall request, 1=Stop
//  flush      in   1        synchronous kill of stage contents (exception/eret)
//  ex_wd      in   ADDR_W   EX destination GPR
//  ex_wreg    in   1        EX GPR write enable
//  ex_wdata   in   DATA_W   EX GPR write data
//  ex_hi      in   DATA_W   EX HI value
//  ex_lo      in   DATA_W   EX LO value
//  ex_whilo   in   1        EX HI/LO write enable
//  hilo_i     in   ACC_W    partial accumulator from EX
//  cnt_i      in   CNT_W    multi-cycle step count from EX
//  mem_wd     out  ADDR_W   registered ex_wd
//  mem_wreg   out  1        registered ex_wreg
//  mem_wdata  out  DATA_W   registered ex_wdata
//  mem_hi     out  DATA_W   registered ex_hi
//  mem_lo     out  DATA_W   registered ex_lo
//  mem_whilo  out  1        registered ex_whilo
//  mem_valid  out  1        1 = real instruction in MEM, 0 = bubble
//  hilo_o     out  ACC_W    accumulator returned to EX next cycle
//  cnt_o      out  CNT_W    step count returned to EX next cycle
// BEHAVIOUR
//  - Reset (async, on posedge rst): all outputs 0 (mem_wd=NOPRegAddr=0, enables disabled, valid=0).
//  - All other updates on posedge clk; latency 1 cycle EX->MEM. Priority, highest first:
//    1 flush=1: payload/enables/valid cleared, hilo_o=0, cnt_o=0 (kills in-flight multi-cycle op).
//    2 stall[STAGE_IDX]=1 & stall[STAGE_IDX+1]=0 (bubble): payload cleared, wreg=whilo=valid=0;
//      hilo_o<=hilo_i, cnt_o<=cnt_i (accumulator kept alive while EX iterates).
//    3 stall[STAGE_IDX]=0 (advance): all mem_* <= ex_*, mem_valid=1; hilo_o=0, cnt_o=0.
//    4 both stalled (hold): mem_* and mem_valid unchanged; hilo_o<=hilo_i, cnt_o<=cnt_i.
//  - Bits of stall other than STAGE_IDX / STAGE_IDX+1 are ignored.
//  - flush with stall asserted: flush wins. rst mid-multi-cycle: accumulator lost, cnt_o=0.
//  - cnt_o is a pure register of cnt_i; no arithmetic or wrap logic here (EX owns counting).
//  - Bubble data is all-zero so forwarding logic never sees stale wd with wreg=1.
// CONFIGURATION
//  EX_MEM_PERF_EN defined: adds outputs perf_bubble_cnt[31:0] and perf_hold_cnt[31:0], reset to 0,
//    cleared by flush; +1 on each bubble (case 2) / hold (case 4) cycle; saturate at 32'hFFFF_FFFF.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 rst=1 mid-cycle with outputs nonzero -> all outputs 0 immediately, before next clk edge.
//  2 stall=0, ex_wd=5'd8, ex_wreg=1, ex_wdata=32'hDEADBEEF -> next cycle mem_wd=8, mem_wdata=DEADBEEF, valid=1.
//  3 stall=6'b001111, hilo_i=64'h1_0000_0002, cnt_i=1 -> mem_wreg=0, valid=0, hilo_o=64'h1_0000_0002, cnt_o=1.
//  4 stall=6'b011111 after a capture of wdata=32'h12345678 -> mem_* held 3 cycles, hilo_o tracks hilo_i.
//  5 flush=1 with stall=6'b001111, cnt_i=2 -> all outputs 0, cnt_o=0; flush and stall both clear next cycle -> normal advance.
//  6 EX_MEM_PERF_EN: 3 bubble + 2 hold cycles -> perf_bubble_cnt=3, perf_hold_cnt=2; flush -> both 0.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall/bubble/hold handling, flush, valid bit and accumulator loop-back.
// Optional build macro EX_MEM_PERF_EN adds saturating bubble/hold performance counters.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ACC_W     = 64,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE_IDX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  ex_wd,
  input  logic               ex_wreg,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic [DATA_W-1:0]  ex_hi,
  input  logic [DATA_W-1:0]  ex_lo,
  input  logic               ex_whilo,
  input  logic [ACC_W-1:0]   hilo_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [ADDR_W-1:0]  mem_wd,
  output logic               mem_wreg,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  mem_hi,
  output logic [DATA_W-1:0]  mem_lo,
  output logic               mem_whilo,
  output logic               mem_valid,
  output logic [ACC_W-1:0]   hilo_o,
  output logic [CNT_W-1:0]   cnt_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]        perf_bubble_cnt,
  output logic [31:0]        perf_hold_cnt
`endif
);

  localparam int unsigned PERF_W = 32;

  logic ex_stall;
  logic mem_stall;
  logic bubble;
  logic hold;
  logic unused_stall;

  assign ex_stall     = stall[STAGE_IDX];
  assign mem_stall    = stall[STAGE_IDX+1];
  assign bubble       = ex_stall & ~mem_stall;
  assign hold         = ex_stall & mem_stall;
  // Other stages' stall bits do not affect this register.
  assign unused_stall = ^stall;

  // Pipeline payload and accumulator loop-back; flush > bubble > advance > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      mem_valid <= 1'b0;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else if (flush) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      mem_valid <= 1'b0;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else if (bubble) begin
      // All-zero bubble so forwarding never sees a stale wd with wreg set.
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      mem_valid <= 1'b0;
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end else if (!ex_stall) begin
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_wdata <= ex_wdata;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      mem_whilo <= ex_whilo;
      mem_valid <= 1'b1;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else begin
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end
  end

`ifdef EX_MEM_PERF_EN
  // Saturating bubble/hold cycle counters, cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_hold_cnt   <= '0;
    end else if (flush) begin
      perf_bubble_cnt <= '0;
      perf_hold_cnt   <= '0;
    end else begin
      if (bubble && (perf_bubble_cnt != '1)) perf_bubble_cnt <= perf_bubble_cnt + PERF_W'(1);
      if (hold && (perf_hold_cnt != '1))     perf_hold_cnt   <= perf_hold_cnt + PERF_W'(1);
    end
  end
`endif

endmodule
